// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence link (transmitter and detector).
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAR,
    GAP
  } seq_state_t;

  localparam logic [3:0] PREAMBLE_1011 = 4'b1011;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable MSB-first shift register with a bit down-counter; last flags the final bit.
module seq_tx_shifter #(
  parameter int unsigned SH_W = 8,
  parameter int unsigned CW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [SH_W-1:0] load_val,
  input  logic [CW-1:0]   width,
  output logic            cur_bit,
  output logic            last
);

  logic [SH_W-1:0] sr;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_val;
      cnt <= width - 1'b1;
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt - 1'b1;
    end
  end

  assign cur_bit = sr[SH_W-1];
  assign last    = (cnt == '0);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB-first, optional even parity, idle gap.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int unsigned      DATA_W     = 8,
  parameter int unsigned      PRE_W      = 4,
  parameter logic [PRE_W-1:0] PREAMBLE   = PREAMBLE_1011,
  parameter bit               PARITY_EN  = 1'b1,
  parameter int unsigned      GAP_CYCLES = 1,
  parameter logic             IDLE_BIT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned SH_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned CW   = $clog2(max3(PRE_W, DATA_W, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  seq_state_t        state, state_n;
  logic [DATA_W-1:0] payload;
  logic              parity;
  logic [CW-1:0]     gap_cnt;
  logic              accept, gap_load;
  logic              sh_load, sh_shift, sh_bit, sh_last;
  logic [SH_W-1:0]   sh_val;
  logic [CW-1:0]     sh_width;
  logic [SH_W-1:0]   pre_al, pay_al;

  // Both phases share one shifter, so each word is left-aligned to its MSB.
  assign pre_al = SH_W'(PREAMBLE) << (SH_W - PRE_W);
  assign pay_al = SH_W'(payload) << (SH_W - DATA_W);

  seq_tx_shifter #(
    .SH_W(SH_W),
    .CW  (CW)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .load_val(sh_val),
    .width   (sh_width),
    .cur_bit (sh_bit),
    .last    (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      payload <= '0;
      parity  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        payload <= in_data;
        parity  <= ^in_data;
      end
      if (gap_load) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    gap_load = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_val   = '0;
    sh_width = '0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_n  = PRE;
          sh_load  = 1'b1;
          sh_val   = pre_al;
          sh_width = CW'(PRE_W);
        end
      end
      PRE: begin
        if (sh_last) begin
          state_n  = DATA;
          sh_load  = 1'b1;
          sh_val   = pay_al;
          sh_width = CW'(DATA_W);
        end else begin
          sh_shift = 1'b1;
        end
      end
      DATA: begin
        if (sh_last) begin
          if (PARITY_EN) begin
            state_n = PAR;
          end else if (GAP_CYCLES > 0) begin
            state_n  = GAP;
            gap_load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
      PAR: begin
        if (GAP_CYCLES > 0) begin
          state_n  = GAP;
          gap_load = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == PRE) || (state == DATA) || (state == PAR);
  assign out_bit    = (state == PRE || state == DATA) ? sh_bit :
                      (state == PAR)                  ? parity : IDLE_BIT;
  assign frame_done = PARITY_EN ? (state == PAR) : (state == DATA && sh_last);

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench: two transmitter configurations checked cycle by cycle against a frame-list model.
module tb_seq_frame_tx;

  typedef struct packed {
    logic v;
    logic b;
    logic d;
  } exp_t;

  localparam logic [3:0] TB_PRE = 4'b1011;
  localparam int unsigned TB_PRE_W = 4;
  localparam int unsigned TB_DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       iv [0:1];
  logic [7:0] id [0:1];
  logic rd [0:1], ob [0:1], ov [0:1], bz [0:1], fd [0:1];

  bit pen [0:1];
  int gapn [0:1];

  exp_t fb [0:1][0:31];
  int   pos [0:1];
  int   cnt [0:1];
  bit   acc [0:1];

  int nchk = 0;
  int nfail = 0;
  int vc [0:1];
  int dc [0:1];
  logic [3:0] hist;
  int hits, hit_pos;
  logic [7:0] pq0 [$];
  logic [7:0] pq1 [$];

  always #5 clk = ~clk;

  seq_frame_tx dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(rd[0]),
    .out_bit(ob[0]), .out_valid(ov[0]), .busy(bz[0]), .frame_done(fd[0])
  );

  seq_frame_tx #(
    .PARITY_EN (1'b0),
    .GAP_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(rd[1]),
    .out_bit(ob[1]), .out_valid(ov[1]), .busy(bz[1]), .frame_done(fd[1])
  );

  // Reference: a handshake expands into a flat list of expected cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        pos[i] = 0;
        cnt[i] = 0;
      end else if (pos[i] < cnt[i]) begin
        pos[i]++;
      end else if (iv[i] === 1'b1) begin
        int n;
        logic [7:0] d;
        n = 0;
        d = id[i];
        for (int k = TB_PRE_W - 1; k >= 0; k--) begin
          fb[i][n] = '{v: 1'b1, b: TB_PRE[k], d: 1'b0};
          n++;
        end
        for (int k = TB_DW - 1; k >= 0; k--) begin
          fb[i][n] = '{v: 1'b1, b: d[k], d: (k == 0 && !pen[i])};
          n++;
        end
        if (pen[i]) begin
          fb[i][n] = '{v: 1'b1, b: ($countones(d) % 2 == 1), d: 1'b1};
          n++;
        end
        for (int g = 0; g < gapn[i]; g++) begin
          fb[i][n] = '{v: 1'b0, b: 1'b0, d: 1'b0};
          n++;
        end
        cnt[i] = n;
        pos[i] = 0;
        acc[i] = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    logic er, eb;
    for (int i = 0; i < 2; i++) begin
      if (pos[i] < cnt[i]) begin
        e = fb[i][pos[i]];
        er = 1'b0;
        eb = 1'b1;
      end else begin
        e = '{v: 1'b0, b: 1'b0, d: 1'b0};
        er = 1'b1;
        eb = 1'b0;
      end
      chk($sformatf("d%0d_out_valid", i), 32'(ov[i]), 32'(e.v));
      chk($sformatf("d%0d_out_bit", i), 32'(ob[i]), 32'(e.b));
      chk($sformatf("d%0d_frame_done", i), 32'(fd[i]), 32'(e.d));
      chk($sformatf("d%0d_in_ready", i), 32'(rd[i]), 32'(er));
      chk($sformatf("d%0d_busy", i), 32'(bz[i]), 32'(eb));
      if (ov[i] === 1'b1) vc[i]++;
      if (fd[i] === 1'b1) dc[i]++;
    end
    hist = {hist[2:0], ob[0]};
    if (hist == 4'b1011) begin
      hits++;
      hit_pos = (pos[0] < cnt[0]) ? pos[0] : -1;
    end
  endtask

  // Upstream holds valid/data until accepted; data is random whenever not offered.
  task automatic drive();
    if (acc[0] && pq0.size() > 0) void'(pq0.pop_front());
    if (acc[1] && pq1.size() > 0) void'(pq1.pop_front());
    if (pq0.size() > 0) begin iv[0] = 1'b1; id[0] = pq0[0]; end
    else begin iv[0] = 1'b0; id[0] = 8'($urandom); end
    if (pq1.size() > 0) begin iv[1] = 1'b1; id[1] = pq1[0]; end
    else begin iv[1] = 1'b0; id[1] = 8'($urandom); end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
      drive();
    end
  endtask

  task automatic push(input logic [7:0] d);
    pq0.push_back(d);
    pq1.push_back(d);
  endtask

  initial begin
    pen[0] = 1'b1; gapn[0] = 1;
    pen[1] = 1'b0; gapn[1] = 0;
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0; cnt[i] = 0; acc[i] = 1'b0; vc[i] = 0; dc[i] = 0;
      iv[i] = 1'b0; id[i] = 8'h00;
    end
    hist = '0; hits = 0; hit_pos = -1;

    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Single frame A5: 13 valid bits with parity, 12 without.
    for (int i = 0; i < 2; i++) begin vc[i] = 0; dc[i] = 0; end
    push(8'hA5);
    drive();
    cyc(20);
    chk("a5_len_par", 32'(vc[0]), 32'd13);
    chk("a5_len_nopar", 32'(vc[1]), 32'd12);
    chk("a5_done_par", 32'(dc[0]), 32'd1);
    chk("a5_done_nopar", 32'(dc[1]), 32'd1);

    push(8'h01);
    drive();
    cyc(20);

    // Back-to-back with valid held high.
    push(8'h3C);
    push(8'hC3);
    drive();
    cyc(40);

    // FF with in_data churning after the handshake.
    push(8'hFF);
    drive();
    cyc(20);

    // Reset while the third payload bit is on the line.
    push(8'h5A);
    drive();
    for (int k = 0; k < 40 && pos[0] != int'(TB_PRE_W) + 2; k++) cyc(1);
    chk("rst_point_reached", 32'(pos[0]), 32'(TB_PRE_W + 2));
    for (int i = 0; i < 2; i++) dc[i] = 0;
    rst = 1'b1;
    pq0.delete();
    pq1.delete();
    cyc(1);
    rst = 1'b0;
    chk("rst_no_done", 32'(dc[0]), 32'd0);
    cyc(2);
    push(8'h96);
    drive();
    cyc(20);

    // Loopback-style detection of 1011 on an all-zero payload.
    cyc(4);
    hist = '0; hits = 0; hit_pos = -1;
    pq0.push_back(8'h00);
    drive();
    cyc(20);
    chk("det_hits", 32'(hits), 32'd1);
    chk("det_pos", 32'(hit_pos), 32'd3);

    // Randomized payloads and spacing.
    for (int r = 0; r < 25; r++) begin
      push(8'($urandom));
      drive();
      cyc(int'($urandom_range(5, 25)));
    end
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
